entropy_byte_streamer: RTL and testbench
========================================

# entropy_byte_streamer

Downstream stage of the serial-to-parallel collector. It captures each completed 384-bit or 160-bit packet on the collector's one-cycle valid pulse and holds it in a two-entry word buffer. It then streams the packet out as bytes over a valid/ready handshake to the host/FIFO interface. Packets that arrive while both buffer entries are occupied are dropped and flagged with a sticky overrun bit.

## Interface
- `WORD_W`, 384: width of word_in; fixed, not for override
- `BYTE_W`, 8: output byte width; fixed
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `word_in`  in  384  parallel packet; valid only in the word_valid_in cycle
- `word_valid_in`  in  1  single-cycle pulse: word_in holds a complete packet
- `sel`  in  2  packet size: 2'b01 is 160 bits (20 bytes); any other value is 384 bits (48 bytes)
- `byte_out`  out  8  current byte
- `byte_valid`  out  1  byte_out is valid
- `byte_ready`  in  1  consumer accepts byte_out this cycle
- `byte_last`  out  1  byte_out is the final byte of its packet
- `busy`  out  1  at least one buffer entry is occupied
- `overrun`  out  1  sticky: at least one packet was dropped
- `overrun_clr`  in  1  clears overrun

## Operation
- **Buffer:** 2 entries, each holding a 384-bit word plus a length flag (20 or 48 bytes).
  - Pointers: wr_ptr, rd_ptr (1 bit each); occupancy count (0..2); byte_idx (6 bits, 0..47) for the head entry.
- **Capture:** on a clk edge with word_valid_in=1:
  - If a slot is free, store word_in and the length decoded from sel at that edge; wr_ptr toggles.
  - A slot counts as free if count<2, or if count==2 and the head entry's last byte hands off on the same edge.
  - Otherwise drop the word and set overrun=1; count and pointers are unchanged.
- **Byte order:** MSB first. With L = packet length in bytes, byte k = word[8L-1-8k : 8L-8-8k].
  - 384-bit packet: byte 0 = word[383:376], byte 47 = word[7:0].
  - 160-bit packet: byte 0 = word[159:152], byte 19 = word[7:0]; word[383:160] is ignored.
- **Handshake:** a byte transfers on any edge with byte_valid && byte_ready.
  - On transfer, byte_idx increments.
  - On the last byte, byte_idx returns to 0, rd_ptr toggles and count decrements.
  - While byte_valid && !byte_ready, byte_out and byte_last hold stable.
  - byte_valid never deasserts without a transfer unless reset is applied.
- **Output decode:**
  - byte_valid = (count != 0).
  - byte_last = byte_valid && (byte_idx == L-1).
  - busy = (count != 0).
- **Simultaneous capture and last-byte transfer:** count is unchanged, both pointers advance, and the new word is accepted.
- **Overrun flag:** set on a drop; cleared by overrun_clr. If a drop and overrun_clr occur on the same edge, set wins.
- **Reset:** outputs are byte_valid=0, byte_last=0, busy=0, overrun=0, byte_out=0.
  - count, pointers and byte_idx reset to 0.
  - Buffer data does not require reset.
  - Reset mid-stream discards all buffered data. Streaming does not resume after reset deasserts until a new pulse is captured.

## Timing
- Capture-to-output latency is 1 edge: a pulse sampled at edge t into an empty buffer gives byte_valid=1 and byte 0 on byte_out in the cycle after t.
- Throughput is one byte per cycle with byte_ready held high.
  - A 48-byte packet occupies 48 cycles; a 20-byte packet occupies 20.
  - Back-to-back buffered packets stream with no bubble: byte 0 of the next packet follows byte_last directly.
- byte_out, byte_valid, byte_last and busy are derived from registers only, with no combinational path from byte_ready or word_valid_in. This means byte_out may be a mux of the registered head entry.
- overrun updates on the edge after the drop or clear condition.

## Test plan
- **Single 384-bit packet:** word_in = 384'h0102…2F30 (byte i = i+1), sel=2'b00, byte_ready=1. Require:
  - 48 bytes 0x01..0x30 on consecutive cycles, starting 1 cycle after the pulse.
  - byte_last only with 0x30; then busy=0.
- **160-bit packet:** sel=2'b01, word_in[159:0] = bytes 0xA0..0xB3, upper bits = all ones. Require exactly 20 bytes 0xA0..0xB3, byte_last on 0xB3, and no upper-bit bytes.
- **Backpressure:** toggle byte_ready pseudo-randomly for a 48-byte packet. Require:
  - byte_out stable while byte_valid && !byte_ready.
  - The received sequence is identical to the byte_ready=1 case.
- **Overrun:** byte_ready=0, three pulses 50 cycles apart. Require:
  - The first two packets are held.
  - After the third pulse, overrun=1.
  - Releasing byte_ready streams only packets 1 and 2 (96 bytes).
  - overrun_clr then gives overrun=0.
- **Same-edge free and capture:** count=2, present a pulse on the edge where the head's byte 47 transfers. Require:
  - The word is accepted, overrun stays 0, and 144 bytes total are output in order.
- **Reset mid-stream:** assert rst_n=0 during byte 10. Require:
  - byte_valid=0, busy=0 and overrun=0 immediately.
  - After release, no output until the next pulse, then a clean 48-byte stream.

Source files
------------

// File: rtl/entropy_byte_streamer_if.sv
// Packet-in / byte-out bundle for the entropy byte streamer.
// master drives packets and consumes bytes; slave is the streamer itself.
interface entropy_byte_streamer_if;
  logic [383:0] word_in;
  logic         word_valid_in;
  logic [1:0]   sel;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         byte_last;
  logic         busy;
  logic         overrun;
  logic         overrun_clr;

  modport master (
    output word_in, word_valid_in, sel, byte_ready, overrun_clr,
    input  byte_out, byte_valid, byte_last, busy, overrun
  );

  modport slave (
    input  word_in, word_valid_in, sel, byte_ready, overrun_clr,
    output byte_out, byte_valid, byte_last, busy, overrun
  );
endinterface

// File: rtl/entropy_byte_streamer.sv
// Two-entry packet buffer that streams 20- or 48-byte packets MSB-first over valid/ready.
// Capture-to-first-byte latency 1 cycle; stalls hold the byte, full buffer drops and flags overrun.
module entropy_byte_streamer (
  input  logic                    clk,
  input  logic                    rst_n,
  entropy_byte_streamer_if.slave  bus
);
  localparam int WORD_W = 384;
  localparam int BYTE_W = 8;

  logic [WORD_W-1:0] mem_q [2];
  logic [1:0]        len48_q;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [5:0]        byte_idx_q, byte_idx_d;
  logic              overrun_q, overrun_d;

  logic              valid, last, xfer, pop, free, push, drop;
  logic [5:0]        last_idx, lane;
  logic [BYTE_W-1:0] head_byte;

  // Output side is a pure decode of the head entry, independent of byte_ready.
  always_comb begin
    valid     = (count_q != 2'd0);
    last_idx  = len48_q[rd_ptr_q] ? 6'd47 : 6'd19;
    lane      = last_idx - byte_idx_q;
    head_byte = mem_q[rd_ptr_q][{lane, 3'b000} +: BYTE_W];
    last      = valid && (byte_idx_q == last_idx);
  end

  assign bus.byte_valid = valid;
  assign bus.byte_last  = last;
  assign bus.byte_out   = valid ? head_byte : '0;
  assign bus.busy       = valid;
  assign bus.overrun    = overrun_q;

  // A full buffer still accepts when the head frees its slot on the same edge.
  always_comb begin
    xfer = valid && bus.byte_ready;
    pop  = xfer && last;
    free = (count_q != 2'd2) || pop;
    push = bus.word_valid_in && free;
    drop = bus.word_valid_in && !free;

    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;

    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 2'd1;
    else if (pop && !push)
      count_d = count_q - 2'd1;

    byte_idx_d = byte_idx_q;
    if (pop)
      byte_idx_d = 6'd0;
    else if (xfer)
      byte_idx_d = byte_idx_q + 6'd1;

    overrun_d = overrun_q;
    if (drop)
      overrun_d = 1'b1;
    else if (bus.overrun_clr)
      overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      byte_idx_q <= 6'd0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      overrun_q  <= overrun_d;
    end
  end

  // Payload storage is only ever read behind a nonzero count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]   <= bus.word_in;
      len48_q[wr_ptr_q] <= (bus.sel != 2'b01);
    end
  end
endmodule

// File: tb/tb_entropy_byte_streamer.sv
// Scoreboard bench for entropy_byte_streamer: expected bytes queued at capture, checked on each handshake.
module tb_entropy_byte_streamer;
  logic clk;
  logic rst_n;
  entropy_byte_streamer_if bus_if ();

  entropy_byte_streamer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int         nchk = 0;
  int         nerr = 0;
  int         cyc = 0;
  int         rx_cnt = 0;
  int         first_cyc = 0;
  int         last_cyc = 0;
  int         stall_cnt = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_byte;
  logic       prev_last;
  logic [8:0] sb [$];

  logic [383:0] w_inc, w_160, w_a, w_b, w_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input logic [383:0] w, input logic [1:0] s);
    int len;
    len = (s == 2'b01) ? 20 : 48;
    for (int k = 0; k < len; k++)
      sb.push_back({(k == len - 1), w[8*len-1-8*k -: 8]});
  endtask

  task automatic pulse(input logic [383:0] w, input logic [1:0] s, input bit accept);
    @(posedge clk); #1;
    bus_if.word_valid_in = 1'b1;
    bus_if.word_in       = w;
    bus_if.sel           = s;
    if (accept) push_pkt(w, s);
    @(posedge clk); #1;
    bus_if.word_valid_in = 1'b0;
    bus_if.word_in       = '1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus_if.byte_valid) && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_idle", 32'(bus_if.byte_valid), 32'd0);
  endtask

  function automatic logic [383:0] rand_word();
    logic [383:0] w;
    for (int i = 0; i < 12; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  always @(posedge clk) cyc++;

  // Byte monitor: scoreboard compare on handshake, stability check across stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        check("stall_hold", 32'({bus_if.byte_valid, bus_if.byte_last, bus_if.byte_out}),
              32'({1'b1, prev_last, prev_byte}));
      if (bus_if.byte_valid && bus_if.byte_ready) begin
        if (sb.size() == 0)
          check("sb_nonempty", 32'(sb.size()), 32'd1);
        else
          check("byte", 32'({bus_if.byte_last, bus_if.byte_out}), 32'(sb.pop_front()));
        rx_cnt++;
        if (rx_cnt == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      prev_stall = bus_if.byte_valid && !bus_if.byte_ready;
      if (prev_stall) stall_cnt++;
      prev_byte = bus_if.byte_out;
      prev_last = bus_if.byte_last;
    end
  end

  initial begin
    int n;
    int idle_v;
    clk = 0;
    rst_n = 1;
    bus_if.word_in = '0;
    bus_if.word_valid_in = 0;
    bus_if.sel = 2'b00;
    bus_if.byte_ready = 0;
    bus_if.overrun_clr = 0;

    for (int i = 0; i < 48; i++) w_inc[383-8*i -: 8] = 8'(i + 1);
    w_160 = '1;
    for (int i = 0; i < 20; i++) w_160[159-8*i -: 8] = 8'(8'hA0 + i);

    #1 rst_n = 0;
    #2;
    check("rst_valid", 32'(bus_if.byte_valid), 32'd0);
    check("rst_last", 32'(bus_if.byte_last), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_overrun", 32'(bus_if.overrun), 32'd0);
    check("rst_byte", 32'(bus_if.byte_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Single 384-bit packet at full rate
    bus_if.byte_ready = 1;
    rx_cnt = 0;
    pulse(w_inc, 2'b00, 1);
    @(negedge clk);
    check("lat_valid", 32'(bus_if.byte_valid), 32'd1);
    check("lat_byte0", 32'(bus_if.byte_out), 32'h01);
    wait_drain(100);
    check("t1_count", 32'(rx_cnt), 32'd48);
    check("t1_span", 32'(last_cyc - first_cyc), 32'd47);
    check("t1_busy", 32'(bus_if.busy), 32'd0);

    // 160-bit packet, upper bits must never appear
    rx_cnt = 0;
    pulse(w_160, 2'b01, 1);
    wait_drain(100);
    check("t2_count", 32'(rx_cnt), 32'd20);

    // Random backpressure
    rx_cnt = 0;
    stall_cnt = 0;
    bus_if.byte_ready = 0;
    pulse(w_inc, 2'b00, 1);
    n = 0;
    while ((sb.size() != 0 || bus_if.byte_valid) && n < 1000) begin
      @(posedge clk); #1;
      bus_if.byte_ready = 1'($urandom_range(0, 1));
      n++;
    end
    bus_if.byte_ready = 1;
    wait_drain(10);
    check("t3_count", 32'(rx_cnt), 32'd48);
    check("t3_stalls_seen", 32'(stall_cnt != 0), 32'd1);

    // Overrun: third packet dropped while stalled
    rx_cnt = 0;
    bus_if.byte_ready = 0;
    w_a = rand_word();
    w_b = rand_word();
    w_c = rand_word();
    pulse(w_a, 2'b00, 1);
    @(negedge clk);
    check("t4_head_byte0", 32'(bus_if.byte_out), 32'(w_a[383:376]));
    repeat (50) @(posedge clk);
    pulse(w_b, 2'b00, 1);
    @(negedge clk);
    check("t4_ovr_before", 32'(bus_if.overrun), 32'd0);
    repeat (50) @(posedge clk);
    pulse(w_c, 2'b00, 0);
    @(negedge clk);
    check("t4_ovr_set", 32'(bus_if.overrun), 32'd1);
    check("t4_busy", 32'(bus_if.busy), 32'd1);
    @(posedge clk); #1 bus_if.byte_ready = 1;
    wait_drain(200);
    check("t4_count", 32'(rx_cnt), 32'd96);
    check("t4_ovr_sticky", 32'(bus_if.overrun), 32'd1);
    @(posedge clk); #1 bus_if.overrun_clr = 1;
    @(posedge clk); #1 bus_if.overrun_clr = 0;
    @(negedge clk);
    check("t4_ovr_clr", 32'(bus_if.overrun), 32'd0);

    // Same-edge free and capture on the head's last byte
    rx_cnt = 0;
    bus_if.byte_ready = 0;
    w_a = rand_word();
    w_b = rand_word();
    w_c = rand_word();
    pulse(w_a, 2'b00, 1);
    pulse(w_b, 2'b00, 1);
    @(posedge clk); #1 bus_if.byte_ready = 1;
    repeat (47) @(posedge clk);
    #1;
    bus_if.word_valid_in = 1;
    bus_if.word_in = w_c;
    bus_if.sel = 2'b10;
    push_pkt(w_c, 2'b10);
    @(negedge clk);
    check("t5_last_on_edge", 32'(bus_if.byte_last), 32'd1);
    @(posedge clk); #1;
    bus_if.word_valid_in = 0;
    @(negedge clk);
    check("t5_ovr", 32'(bus_if.overrun), 32'd0);
    wait_drain(300);
    check("t5_count", 32'(rx_cnt), 32'd144);

    // Drop and clear on the same edge: set wins
    bus_if.byte_ready = 0;
    pulse(w_a, 2'b01, 1);
    pulse(w_b, 2'b00, 1);
    @(posedge clk); #1;
    bus_if.overrun_clr = 1;
    bus_if.word_valid_in = 1;
    bus_if.word_in = w_c;
    @(posedge clk); #1;
    bus_if.overrun_clr = 0;
    bus_if.word_valid_in = 0;
    @(negedge clk);
    check("t6_set_wins", 32'(bus_if.overrun), 32'd1);
    bus_if.byte_ready = 1;
    wait_drain(200);

    // Reset mid-stream during byte 10
    rx_cnt = 0;
    pulse(w_inc, 2'b00, 1);
    n = 0;
    while (rx_cnt != 10 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("t7_reached_b10", 32'(rx_cnt), 32'd10);
    #2 rst_n = 0;
    #1;
    check("t7_rst_valid", 32'(bus_if.byte_valid), 32'd0);
    check("t7_rst_busy", 32'(bus_if.busy), 32'd0);
    check("t7_rst_ovr", 32'(bus_if.overrun), 32'd0);
    check("t7_rst_byte", 32'(bus_if.byte_out), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idle_v = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.byte_valid) idle_v++;
    end
    check("t7_no_resume", 32'(idle_v), 32'd0);
    rx_cnt = 0;
    pulse(w_inc, 2'b00, 1);
    wait_drain(100);
    check("t7_count", 32'(rx_cnt), 32'd48);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
